// File: rtl/basic_ram_pkg.sv
// Shared types and helpers for the basic_ram family.
// Holds the sequencer state type, read-mode constants and the parity helper
// used by both ports of param_dp_ram.
package basic_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  // Values for the RD_MODE parameter.
  localparam int RD_FIRST = 0;  // a read colliding with a write returns the old word
  localparam int WR_FIRST = 1;  // a read colliding with a write returns the new word

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PAR_MAX_W = 64;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_rd_port.sv
// Read side of one RAM port: request decode, same-address collision bypass,
// and the registered dout/rvalid/perr outputs.
// Optional feature: `define RAM_PARITY_EN enables the parity check on read.
module ram_rd_port
  import basic_ram_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 5,
  parameter int MEM_W   = 4,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,          // sequencer finished clearing
  input  logic              cs_i,
  input  logic              we_i,
  input  logic              oe_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [MEM_W-1:0]  mem_rdata_i,   // array word at addr_i
  input  logic              peer_wr_i,     // other port writes this cycle
  input  logic [ADDR_W-1:0] peer_addr_i,
  input  logic [MEM_W-1:0]  peer_wdata_i,  // word the other port is storing
  output logic [DATA_W-1:0] dout_o,
  output logic              rvalid_o,
  output logic              perr_o
);

  logic              rd_req;
  logic              bypass;
  logic [MEM_W-1:0]  rd_word;
  logic [DATA_W-1:0] dout_d, dout_q;
  logic              rvalid_d, rvalid_q;
  logic              perr_d, perr_q;

  assign rd_req  = en_i & cs_i & ~we_i & oe_i;
  assign bypass  = (RD_MODE == WR_FIRST) && peer_wr_i && (peer_addr_i == addr_i);
  assign rd_word = bypass ? peer_wdata_i : mem_rdata_i;

  // Next-state for the read registers: load on a read, otherwise hold dout.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    perr_d   = 1'b0;
    if (rd_req) begin
      dout_d   = rd_word[DATA_W-1:0];
      rvalid_d = 1'b1;
`ifdef RAM_PARITY_EN
      perr_d   = parity(PAR_MAX_W'(rd_word[DATA_W-1:0])) != rd_word[MEM_W-1];
`endif
    end
  end

  // Read registers; reset discards any read that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign dout_o   = dout_q;
  assign rvalid_o = rvalid_q;
  assign perr_o   = perr_q;

endmodule

// File: rtl/param_dp_ram.sv
// True dual-port synchronous RAM with a post-reset clear sweep.
// After rst release the sequencer zeroes every word (DEPTH cycles), then
// raises ready and serves ports A and B. Port A wins a same-address
// write collision; RD_MODE picks old or new data on a read/write collision.
// Optional feature: `define RAM_PARITY_EN stores an even-parity bit per word
// and reports mismatches on perr_a/perr_b; otherwise those are tied low.
module param_dp_ram
  import basic_ram_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int RD_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              cs_a,
  input  logic              we_a,
  input  logic              oe_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              rvalid_a,
  input  logic              cs_b,
  input  logic              we_b,
  input  logic              oe_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              rvalid_b,
  output logic              perr_a,
  output logic              perr_b,
  input  logic              inj_err
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  ram_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ready_q;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              wr_a, wr_b;
  logic [MEM_W-1:0]  wdata_a, wdata_b;
  logic              perr_a_int, perr_b_int;

  assign wr_a = ready_q & cs_a & we_a;
  assign wr_b = ready_q & cs_b & we_b;

`ifdef RAM_PARITY_EN
  // inj_err inverts the stored parity bit so the next read flags an error.
  assign wdata_a = {parity(PAR_MAX_W'(din_a)) ^ inj_err, din_a};
  assign wdata_b = {parity(PAR_MAX_W'(din_b)) ^ inj_err, din_b};
  assign perr_a  = perr_a_int;
  assign perr_b  = perr_b_int;
`else
  logic unused_parity;
  assign unused_parity = inj_err ^ perr_a_int ^ perr_b_int;
  assign wdata_a = din_a;
  assign wdata_b = din_b;
  assign perr_a  = 1'b0;
  assign perr_b  = 1'b0;
`endif

  // Clear sequencer: sweep every word once after reset, then stay in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:  ready_q <= 1'b1;
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  // Storage array: clear sweep, else port writes with A applied last so it wins.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it maps onto RAM macros; the sweep zeroes it instead.
    if (state_q == ST_CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else begin
      if (wr_b) mem_q[addr_b] <= wdata_b;
      if (wr_a) mem_q[addr_a] <= wdata_a;
    end
  end

  assign ready = ready_q;

  ram_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MEM_W  (MEM_W),
    .RD_MODE(RD_MODE)
  ) u_port_a (
    .clk         (clk),
    .rst         (rst),
    .en_i        (ready_q),
    .cs_i        (cs_a),
    .we_i        (we_a),
    .oe_i        (oe_a),
    .addr_i      (addr_a),
    .mem_rdata_i (mem_q[addr_a]),
    .peer_wr_i   (wr_b),
    .peer_addr_i (addr_b),
    .peer_wdata_i(wdata_b),
    .dout_o      (dout_a),
    .rvalid_o    (rvalid_a),
    .perr_o      (perr_a_int)
  );

  ram_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MEM_W  (MEM_W),
    .RD_MODE(RD_MODE)
  ) u_port_b (
    .clk         (clk),
    .rst         (rst),
    .en_i        (ready_q),
    .cs_i        (cs_b),
    .we_i        (we_b),
    .oe_i        (oe_b),
    .addr_i      (addr_b),
    .mem_rdata_i (mem_q[addr_b]),
    .peer_wr_i   (wr_a),
    .peer_addr_i (addr_a),
    .peer_wdata_i(wdata_a),
    .dout_o      (dout_b),
    .rvalid_o    (rvalid_b),
    .perr_o      (perr_b_int)
  );

endmodule
